// File: rtl/skew_buf.sv
// Operand skew buffer for the systolic array edge: delays lane i by s_i enabled
// cycles to form the diagonal wavefront, with stall, per-lane valid and a drain FSM.
module skew_buf #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int REVERSE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic                      in_vld,
    input  logic                      in_last,
    output logic                      in_rdy,
    input  logic signed [BITS_AB-1:0] din      [DIM],
    output logic signed [BITS_AB-1:0] dout     [DIM],
    output logic        [DIM-1:0]     dout_vld,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            done_r, done_s;
    logic            accept_s;

    assign in_rdy   = (state_r != DRAIN);
    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign accept_s = en & in_vld & in_rdy;

    // Next-state logic; the counter tracks edges left until the tail reaches the deepest lane.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        if (en) begin
            case (state_r)
                IDLE, RUN: begin
                    if (accept_s) begin
                        if (in_last) begin
                            if (DIM == 1) begin
                                state_s = IDLE;
                                done_s  = 1'b1;
                            end else begin
                                state_s = DRAIN;
                                cnt_s   = CW'(DIM - 1);
                            end
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                DRAIN: begin
                    if (cnt_r <= CW'(1)) begin
                        state_s = IDLE;
                        cnt_s   = {CW{1'b0}};
                        done_s  = 1'b1;
                    end else begin
                        cnt_s   = cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM, drain counter and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else if (clr) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam int S = (REVERSE != 0) ? (DIM - 1 - i) : i;

        logic signed [BITS_AB-1:0] dat_r [S+1];
        logic                      vld_r [S+1];

        // Lane shift chain; bubbles carry zero data so invalid outputs read as 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= S; k++) begin
                    dat_r[k] <= {BITS_AB{1'b0}};
                    vld_r[k] <= 1'b0;
                end
            end else if (clr) begin
                for (int k = 0; k <= S; k++) begin
                    dat_r[k] <= {BITS_AB{1'b0}};
                    vld_r[k] <= 1'b0;
                end
            end else if (en) begin
                dat_r[0] <= accept_s ? din[i] : {BITS_AB{1'b0}};
                vld_r[0] <= accept_s;
                for (int k = 1; k <= S; k++) begin
                    dat_r[k] <= dat_r[k-1];
                    vld_r[k] <= vld_r[k-1];
                end
            end
        end

        assign dout[i]     = dat_r[S];
        assign dout_vld[i] = vld_r[S];
    end

endmodule

// File: tb/tb_skew_buf.sv
// Directed self-checking bench for skew_buf (DIM=4) in both skew directions.
module tb_skew_buf;

    logic              clk = 1'b0;
    logic              rst_n, clr, en, in_vld, in_last;
    logic signed [7:0] din   [4];
    logic signed [7:0] dout  [4];
    logic signed [7:0] dout_r[4];
    logic [3:0]        vld, vld_r;
    logic              rdy, rdy_r, busy, busy_r, done, done_r;
    logic [31:0]       dp, dp_r;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    assign dp   = {dout[3], dout[2], dout[1], dout[0]};
    assign dp_r = {dout_r[3], dout_r[2], dout_r[1], dout_r[0]};

    skew_buf #(.BITS_AB(8), .DIM(4), .REVERSE(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(rdy), .din(din), .dout(dout),
        .dout_vld(vld), .busy(busy), .done(done)
    );

    skew_buf #(.BITS_AB(8), .DIM(4), .REVERSE(1)) dut_rev (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(rdy_r), .din(din), .dout(dout_r),
        .dout_vld(vld_r), .busy(busy_r), .done(done_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [31:0] d, input logic [3:0] v,
                            input logic dn, input logic bz, input logic rd);
        chk({tag, ".data"}, dp, d);
        chk({tag, ".vld"}, {28'd0, vld}, {28'd0, v});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
        chk({tag, ".rdy"}, {31'd0, rdy}, {31'd0, rd});
    endtask

    task automatic chk_rev(input string tag, input logic [31:0] d, input logic [3:0] v,
                           input logic dn, input logic bz, input logic rd);
        chk({tag, ".data"}, dp_r, d);
        chk({tag, ".vld"}, {28'd0, vld_r}, {28'd0, v});
        chk({tag, ".done"}, {31'd0, done_r}, {31'd0, dn});
        chk({tag, ".busy"}, {31'd0, busy_r}, {31'd0, bz});
        chk({tag, ".rdy"}, {31'd0, rdy_r}, {31'd0, rd});
    endtask

    task automatic set_din(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        din[0] = a;
        din[1] = b;
        din[2] = c;
        din[3] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; in_vld = 1'b0; in_last = 1'b0;
        set_din(8'd0, 8'd0, 8'd0, 8'd0);
        #12;
        chk_main("reset", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk_rev("reset_rev", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;

        // Single vector, forward skew
        en = 1'b1; in_vld = 1'b1; in_last = 1'b1;
        set_din(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        chk_main("single.e0", 32'h00000001, 4'b0001, 1'b0, 1'b1, 1'b0);
        in_vld = 1'b0; in_last = 1'b0;
        step();
        chk_main("single.e1", 32'h00000200, 4'b0010, 1'b0, 1'b1, 1'b0);
        step();
        chk_main("single.e2", 32'h00030000, 4'b0100, 1'b0, 1'b1, 1'b0);
        step();
        chk_main("single.e3", 32'h04000000, 4'b1000, 1'b1, 1'b0, 1'b1);
        step();
        chk_main("single.e4", 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Four-vector stream, row r element j = 10r+j
        in_vld = 1'b1; in_last = 1'b0;
        set_din(8'd0, 8'd1, 8'd2, 8'd3);
        step();
        chk_main("stream.e0", 32'h00000000, 4'b0001, 1'b0, 1'b1, 1'b1);
        set_din(8'd10, 8'd11, 8'd12, 8'd13);
        step();
        chk_main("stream.e1", 32'h0000010A, 4'b0011, 1'b0, 1'b1, 1'b1);
        set_din(8'd20, 8'd21, 8'd22, 8'd23);
        step();
        chk_main("stream.e2", 32'h00020B14, 4'b0111, 1'b0, 1'b1, 1'b1);
        set_din(8'd30, 8'd31, 8'd32, 8'd33); in_last = 1'b1;
        step();
        chk_main("stream.e3", 32'h030C151E, 4'b1111, 1'b0, 1'b1, 1'b0);
        in_vld = 1'b0; in_last = 1'b0;
        step();
        chk_main("stream.e4", 32'h0D161F00, 4'b1110, 1'b0, 1'b1, 1'b0);
        step();
        chk_main("stream.e5", 32'h17200000, 4'b1100, 1'b0, 1'b1, 1'b0);
        step();
        chk_main("stream.e6", 32'h21000000, 4'b1000, 1'b1, 1'b0, 1'b1);
        step();
        chk_main("stream.e7", 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Same stream with a two-cycle stall after edge 1
        in_vld = 1'b1;
        set_din(8'd0, 8'd1, 8'd2, 8'd3);
        step();
        set_din(8'd10, 8'd11, 8'd12, 8'd13);
        step();
        chk_main("stall.e1", 32'h0000010A, 4'b0011, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        set_din(8'd20, 8'd21, 8'd22, 8'd23);
        step();
        chk_main("stall.hold0", 32'h0000010A, 4'b0011, 1'b0, 1'b1, 1'b1);
        step();
        chk_main("stall.hold1", 32'h0000010A, 4'b0011, 1'b0, 1'b1, 1'b1);
        en = 1'b1;
        step();
        chk_main("stall.e2", 32'h00020B14, 4'b0111, 1'b0, 1'b1, 1'b1);
        set_din(8'd30, 8'd31, 8'd32, 8'd33); in_last = 1'b1;
        step();
        chk_main("stall.e3", 32'h030C151E, 4'b1111, 1'b0, 1'b1, 1'b0);
        in_vld = 1'b0; in_last = 1'b0;
        step();
        step();
        chk_main("stall.e5", 32'h17200000, 4'b1100, 1'b0, 1'b1, 1'b0);
        step();
        chk_main("stall.e6", 32'h21000000, 4'b1000, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        step();
        chk_main("stall.done_drop", 32'h21000000, 4'b1000, 1'b0, 1'b0, 1'b1);

        // clr with en=0 still flushes
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        chk_main("clr_noen", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk_rev("clr_noen_rev", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Reverse skew, with vectors offered during DRAIN dropped
        in_vld = 1'b1; in_last = 1'b1;
        set_din(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        chk_rev("rev.e0", 32'h04000000, 4'b1000, 1'b0, 1'b1, 1'b0);
        in_last = 1'b0;
        set_din(8'd9, 8'd9, 8'd9, 8'd9);
        step();
        chk_rev("rev.e1", 32'h00030000, 4'b0100, 1'b0, 1'b1, 1'b0);
        step();
        chk_rev("rev.e2", 32'h00000200, 4'b0010, 1'b0, 1'b1, 1'b0);
        in_vld = 1'b0;
        step();
        chk_rev("rev.e3", 32'h00000001, 4'b0001, 1'b1, 1'b0, 1'b1);
        step();
        chk_rev("rev.e4", 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk_main("rev.main_flushed", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // clr mid-DRAIN suppresses done; next vector accepted right after
        in_vld = 1'b1; in_last = 1'b1;
        set_din(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        in_vld = 1'b0; in_last = 1'b0;
        step();
        chk_main("clr.pre", 32'h00000200, 4'b0010, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_main("clr.flush", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        in_vld = 1'b1;
        set_din(8'd5, 8'd6, 8'd7, 8'd8);
        step();
        chk_main("clr.new", 32'h00000005, 4'b0001, 1'b0, 1'b1, 1'b1);
        in_vld = 1'b0;
        step();
        chk_main("clr.new_e1", 32'h00000600, 4'b0010, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle, mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("async_rst", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        chk_main("async_rst_hold", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
